// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding and the default datapath width.
package alu_pkg;

  localparam int ALU_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    OP_AND     = 2'b00,
    OP_OR      = 2'b01,
    OP_NOT_A   = 2'b10,
    OP_ILLEGAL = 2'b11
  } opcode_t;

endpackage

// File: rtl/bitwise_logic_core.sv
// Combinational logic slice: AND / OR / NOT_A gates plus the opcode select mux.
module bitwise_logic_core
  import alu_pkg::*;
#(
  parameter int N = ALU_DEFAULT_WIDTH
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  opcode_t      op,
  output logic [N-1:0] f,
  output logic         is_illegal
);

  always_comb begin
    f          = '0;
    is_illegal = 1'b0;
    case (op)
      OP_AND:   f = a & b;
      OP_OR:    f = a | b;
      OP_NOT_A: f = ~a;
      default: begin
        // The reserved opcode yields an all-zero result so the zero flag is set too.
        f          = '0;
        is_illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/bitwise_logic_unit.sv
// Registered bitwise logic unit: one pipeline stage with valid/ready handshake
// and registered zero / illegal-opcode flags.
module bitwise_logic_unit
  import alu_pkg::*;
#(
  parameter int N = ALU_DEFAULT_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [1:0]   op,
  output logic [N-1:0] res,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         zero,
  output logic         illegal
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both
  // high; a source holding valid must keep its payload stable until ready. The
  // stage accepts whenever it is empty or its result is drained on the same edge.

  logic [N-1:0] r_res;
  logic         r_out_valid;
  logic         r_zero;
  logic         r_illegal;

  logic [N-1:0] w_f;
  logic         w_is_illegal;
  logic         w_accept;
  logic         w_drain;

  bitwise_logic_core #(.N(N)) u_core (
    .a          (a),
    .b          (b),
    .op         (opcode_t'(op)),
    .f          (w_f),
    .is_illegal (w_is_illegal)
  );

  assign in_ready = ~r_out_valid | out_ready;
  assign w_accept = in_valid & in_ready;
  assign w_drain  = r_out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_res       <= '0;
      r_out_valid <= 1'b0;
      r_zero      <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (w_accept) begin
      r_res       <= w_f;
      r_zero      <= (w_f == '0);
      r_illegal   <= w_is_illegal;
      r_out_valid <= 1'b1;
    end else if (w_drain) begin
      // Payload registers keep their last values after a drain.
      r_out_valid <= 1'b0;
    end
  end

  assign res       = r_res;
  assign out_valid = r_out_valid;
  assign zero      = r_zero;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Directed bench for bitwise_logic_unit at N=8 and N=32 with hand-computed expectations.
module tb_bitwise_logic_unit;
  import alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [1:0]  op;
  logic [7:0]  a, b;
  logic [31:0] a32, b32;

  logic        in_ready, out_valid, zero, illegal;
  logic [7:0]  res;
  logic        in_ready32, out_valid32, zero32, illegal32;
  logic [31:0] res32;

  int n_cmp  = 0;
  int n_fail = 0;

  bitwise_logic_unit #(.N(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .res       (res),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .zero      (zero),
    .illegal   (illegal)
  );

  bitwise_logic_unit #(.N(32)) dut32 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready32),
    .a         (a32),
    .b         (b32),
    .op        (op),
    .res       (res32),
    .out_valid (out_valid32),
    .out_ready (out_ready),
    .zero      (zero32),
    .illegal   (illegal32)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    op        = OP_AND;
    a         = 8'hF0;
    b         = 8'h3C;
    a32       = 32'h0;
    b32       = 32'h0;

    // Reset held for two edges with a live AND request
    tick();
    tick();
    check("rst_res",        res,        8'h00);
    check("rst_out_valid",  out_valid,  1'b0);
    check("rst_zero",       zero,       1'b0);
    check("rst_illegal",    illegal,    1'b0);
    check("rst_in_ready",   in_ready,   1'b1);
    check("rst_res32",      res32,      32'h0);
    check("rst_in_ready32", in_ready32, 1'b1);

    // Back-to-back ops, out_ready=1
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();
    check("and_res",  res,       8'h30);
    check("and_ov",   out_valid, 1'b1);
    check("and_zero", zero,      1'b0);
    op = OP_OR;
    tick();
    check("or_res", res,       8'hFC);
    check("or_ov",  out_valid, 1'b1);
    op = OP_NOT_A;
    tick();
    check("not_res", res,       8'h0F);
    check("not_ov",  out_valid, 1'b1);
    a = 8'hFF;
    b = 8'h12;
    tick();
    check("not_ff_res",  res,  8'h00);
    check("not_ff_zero", zero, 1'b1);
    check("not_ff_ov",   out_valid, 1'b1);

    // Illegal opcode
    op = OP_ILLEGAL;
    a  = 8'hAA;
    b  = 8'h55;
    tick();
    check("ill_res",     res,       8'h00);
    check("ill_illegal", illegal,   1'b1);
    check("ill_zero",    zero,      1'b1);
    check("ill_ov",      out_valid, 1'b1);
    op = OP_AND;
    a  = 8'hAA;
    b  = 8'hAA;
    tick();
    check("post_ill_res",     res,     8'hAA);
    check("post_ill_illegal", illegal, 1'b0);
    check("post_ill_zero",    zero,    1'b0);

    // Backpressure
    a = 8'h0F;
    b = 8'hFF;
    tick();
    check("bp_and_res", res, 8'h0F);
    out_ready = 1'b0;
    op        = OP_OR;
    a         = 8'h01;
    b         = 8'h02;
    #1;
    check("bp_in_ready_pre", in_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_in_ready", in_ready,  1'b0);
      check("bp_res",      res,       8'h0F);
      check("bp_ov",       out_valid, 1'b1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", in_ready, 1'b1);
    tick();
    check("bp_or_res", res,       8'h03);
    check("bp_or_ov",  out_valid, 1'b1);

    // Drain without refill, then idle hold
    in_valid = 1'b0;
    tick();
    check("drain_ov",       out_valid, 1'b0);
    check("drain_res",      res,       8'h03);
    check("drain_in_ready", in_ready,  1'b1);
    tick();
    check("idle_ov",  out_valid, 1'b0);
    check("idle_res", res,       8'h03);

    // Reset mid-stall
    in_valid = 1'b1;
    op       = OP_AND;
    a        = 8'h0F;
    b        = 8'h0F;
    tick();
    check("pre_stall_res", res, 8'h0F);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    tick();
    check("stall_ov", out_valid, 1'b1);
    rst_n = 1'b0;
    tick();
    check("mid_rst_res",      res,       8'h00);
    check("mid_rst_ov",       out_valid, 1'b0);
    check("mid_rst_zero",     zero,      1'b0);
    check("mid_rst_illegal",  illegal,   1'b0);
    check("mid_rst_in_ready", in_ready,  1'b1);

    // N=32 ops
    rst_n     = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    op        = OP_AND;
    a32       = 32'hFFFF0000;
    b32       = 32'h00FFFF00;
    tick();
    check("w32_and_res", res32,       32'h00FF0000);
    check("w32_and_ov",  out_valid32, 1'b1);
    op = OP_OR;
    tick();
    check("w32_or_res", res32, 32'hFFFFFF00);
    op = OP_NOT_A;
    tick();
    check("w32_not_res",  res32,  32'h0000FFFF);
    check("w32_not_zero", zero32, 1'b0);
    op = OP_ILLEGAL;
    tick();
    check("w32_ill_res",     res32,     32'h0);
    check("w32_ill_illegal", illegal32, 1'b1);
    check("w32_ill_zero",    zero32,    1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
